// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encodings, grant IDs and the default timeout.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    localparam int DEF_TIMEOUT_CYC = 16;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU fetch, CPU load/store and RAM-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the CPU/RAM side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    logic              bus_err;
    logic              err_sticky;

    modport slave (
        input  inst_req, inst_addr,
        output inst_ack, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ack, data_rdata,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack,
        output bus_err, err_sticky
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_ack, inst_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ack, data_rdata,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack,
        input  bus_err, err_sticky
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_timer.sv
// mem_arb_timer: 8-bit up-counter with clear and enable; expired flags the
// last allowed cycle (count == LIMIT-1) of a memory transaction.
module mem_arb_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST_CNT = 8'(LIMIT - 1);

    logic [7:0] count_r;

    // Cycle counter, held at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en) begin
            count_r <= count_r + 8'd1;
        end
    end

    assign expired = (count_r == LAST_CNT);

endmodule : mem_arb_timer

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and load/store,
// with a per-transaction timeout. Define ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              cpu_rst_n,
    mem_port_arbiter_if.slave bus
);
    arb_state_t state_r;
    arb_state_t state_next_s;
    logic       pick_data_s;
    logic       grant_inst_s;
    logic       grant_data_s;
    logic       done_ok_s;
    logic       done_to_s;
    logic       in_grant_s;
    logic       expired_s;

    assign in_grant_s = (state_r == ARB_GRANT_I) || (state_r == ARB_GRANT_D);

    mem_arb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (cpu_rst_n),
        .clr     (!in_grant_s),
        .en      (in_grant_s),
        .expired (expired_s)
    );

`ifdef ARB_RR_EN
    gnt_t last_grant_r;

    // Remember which port won the most recent grant
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            last_grant_r <= GNT_INST;
        end else if (grant_data_s) begin
            last_grant_r <= GNT_DATA;
        end else if (grant_inst_s) begin
            last_grant_r <= GNT_INST;
        end
    end

    // On contention, favour the port that did not win last time
    always_comb begin
        if (bus.data_req && bus.inst_req) begin
            pick_data_s = (last_grant_r == GNT_INST);
        end else begin
            pick_data_s = bus.data_req;
        end
    end
`else
    // Data port always wins on contention
    always_comb begin
        pick_data_s = bus.data_req;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and transaction event decode
    always_comb begin
        state_next_s = state_r;
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        done_ok_s    = 1'b0;
        done_to_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_data_s) begin
                    grant_data_s = 1'b1;
                    state_next_s = ARB_GRANT_D;
                end else if (bus.inst_req) begin
                    grant_inst_s = 1'b1;
                    state_next_s = ARB_GRANT_I;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                // A late ack on the final cycle still counts as success
                if (bus.ram_ack) begin
                    done_ok_s    = 1'b1;
                    state_next_s = ARB_RESP;
                end else if (expired_s) begin
                    done_to_s    = 1'b1;
                    state_next_s = ARB_RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ARB_RESP: begin
                state_next_s = ARB_IDLE;
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // RAM request launch, response capture and error reporting
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            bus.ram_req    <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= {ADDR_W{1'b0}};
            bus.ram_wdata  <= {DATA_W{1'b0}};
            bus.inst_ack   <= 1'b0;
            bus.data_ack   <= 1'b0;
            bus.inst_rdata <= {DATA_W{1'b0}};
            bus.data_rdata <= {DATA_W{1'b0}};
            bus.bus_err    <= 1'b0;
            bus.err_sticky <= 1'b0;
        end else begin
            bus.inst_ack <= 1'b0;
            bus.data_ack <= 1'b0;
            bus.bus_err  <= 1'b0;
            if (grant_data_s) begin
                bus.ram_req   <= 1'b1;
                bus.ram_we    <= bus.data_we;
                bus.ram_addr  <= bus.data_addr;
                bus.ram_wdata <= bus.data_wdata;
            end else if (grant_inst_s) begin
                bus.ram_req  <= 1'b1;
                bus.ram_we   <= 1'b0;
                bus.ram_addr <= bus.inst_addr;
            end else if (done_ok_s || done_to_s) begin
                bus.ram_req <= 1'b0;
                bus.bus_err <= done_to_s;
                if (done_to_s) begin
                    bus.err_sticky <= 1'b1;
                end
                if (state_r == ARB_GRANT_D) begin
                    bus.data_ack   <= 1'b1;
                    bus.data_rdata <= done_ok_s ? bus.ram_rdata : {DATA_W{1'b0}};
                end else begin
                    bus.inst_ack   <= 1'b1;
                    bus.inst_rdata <= done_ok_s ? bus.ram_rdata : {DATA_W{1'b0}};
                end
            end
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter; expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .cpu_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
        bus.ram_ack = 1'b0; bus.ram_rdata = 32'h0;
        tick(); tick();
        checks++;
        if ({bus.ram_req, bus.ram_we, bus.inst_ack, bus.data_ack, bus.bus_err, bus.err_sticky} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.ram_req, bus.ram_we, bus.inst_ack, bus.data_ack, bus.bus_err, bus.err_sticky});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wdata, bus.inst_rdata, bus.data_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h irdata %h drdata %h expected all 0",
                     bus.ram_addr, bus.ram_wdata, bus.inst_rdata, bus.data_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_inst_fetch();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h40;
        tick();
        checks++;
        if ({bus.ram_req, bus.ram_we} !== 2'b10 || bus.ram_addr !== 32'h40) begin
            errors++;
            $display("FAIL fetch_grant: req/we %b addr %h expected 10 / 00000040",
                     {bus.ram_req, bus.ram_we}, bus.ram_addr);
        end
        bus.inst_addr = 32'h99;
        tick();
        checks++;
        if (bus.ram_addr !== 32'h40 || bus.inst_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: addr %h ack %b expected 00000040 / 0", bus.ram_addr, bus.inst_ack);
        end
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h2010_0004;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== 1'b1 || bus.inst_rdata !== 32'h2010_0004 || bus.data_ack !== 1'b0 || bus.ram_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack: iack %b irdata %h dack %b ram_req %b expected 1 / 20100004 / 0 / 0",
                     bus.inst_ack, bus.inst_rdata, bus.data_ack, bus.ram_req);
        end
        bus.inst_req = 1'b0;
        tick();
        checks++;
        if (bus.inst_ack !== 1'b0 || bus.ram_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: iack %b ram_req %b expected 0 / 0", bus.inst_ack, bus.ram_req);
        end
    endtask

    task automatic test_priority();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h80;
        bus.data_req = 1'b1; bus.data_we = 1'b1;
        bus.data_addr = 32'h100; bus.data_wdata = 32'hCAFE_F00D;
        tick();
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ram_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL prio_store_grant: we %b addr %h wdata %h expected 1 / 00000100 / cafef00d",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h5555_AAAA;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.data_ack !== 1'b1 || bus.inst_ack !== 1'b0 || bus.data_rdata !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL prio_store_ack: dack %b iack %b drdata %h expected 1 / 0 / 5555aaaa",
                     bus.data_ack, bus.inst_ack, bus.data_rdata);
        end
        bus.data_req = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h80) begin
            errors++;
            $display("FAIL prio_fetch_grant: req %b we %b addr %h expected 1 / 0 / 00000080",
                     bus.ram_req, bus.ram_we, bus.ram_addr);
        end
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h1111_2222;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== 1'b1 || bus.inst_rdata !== 32'h1111_2222 || bus.data_rdata !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL prio_fetch_ack: iack %b irdata %h drdata %h expected 1 / 11112222 / 5555aaaa",
                     bus.inst_ack, bus.inst_rdata, bus.data_rdata);
        end
        bus.inst_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic        exp_inst_first;
        logic [31:0] exp_addr;
`ifdef ARB_RR_EN
        exp_inst_first = 1'b1;
`else
        exp_inst_first = 1'b0;
`endif
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h180;
        tick();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h0BAD_BEEF;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.data_ack !== 1'b1 || bus.data_rdata !== 32'h0BAD_BEEF) begin
            errors++;
            $display("FAIL rr_load: dack %b drdata %h expected 1 / 0badbeef", bus.data_ack, bus.data_rdata);
        end
        bus.data_req = 1'b0;
        tick();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h84;
        bus.data_req = 1'b1; bus.data_we = 1'b1;
        bus.data_addr = 32'h104; bus.data_wdata = 32'h1234_5678;
        tick();
        exp_addr = exp_inst_first ? 32'h84 : 32'h104;
        checks++;
        if (bus.ram_addr !== exp_addr || bus.ram_we !== !exp_inst_first) begin
            errors++;
            $display("FAIL rr_first_grant: addr %h we %b expected %h / %b",
                     bus.ram_addr, bus.ram_we, exp_addr, !exp_inst_first);
        end
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h7777_8888;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== exp_inst_first || bus.data_ack !== !exp_inst_first) begin
            errors++;
            $display("FAIL rr_first_ack: iack %b dack %b expected %b / %b",
                     bus.inst_ack, bus.data_ack, exp_inst_first, !exp_inst_first);
        end
        if (exp_inst_first) bus.inst_req = 1'b0;
        else                bus.data_req = 1'b0;
        tick();
        tick();
        exp_addr = exp_inst_first ? 32'h104 : 32'h84;
        checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_addr !== exp_addr) begin
            errors++;
            $display("FAIL rr_second_grant: req %b addr %h expected 1 / %h", bus.ram_req, bus.ram_addr, exp_addr);
        end
        bus.ram_ack = 1'b1;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== !exp_inst_first || bus.data_ack !== exp_inst_first || bus.data_rdata !== 32'h7777_8888) begin
            errors++;
            $display("FAIL rr_second_ack: iack %b dack %b drdata %h expected %b / %b / 77778888",
                     bus.inst_ack, bus.data_ack, bus.data_rdata, !exp_inst_first, exp_inst_first);
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h200;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (bus.ram_req !== 1'b1) break;
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL timeout_len: ram_req high %0d cycles expected 16", cnt);
        end
        checks++;
        if (bus.data_ack !== 1'b1 || bus.bus_err !== 1'b1 || bus.data_rdata !== 32'h0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL timeout_resp: dack %b bus_err %b drdata %h sticky %b expected 1 / 1 / 00000000 / 1",
                     bus.data_ack, bus.bus_err, bus.data_rdata, bus.err_sticky);
        end
        bus.data_req = 1'b0;
        tick();
        checks++;
        if (bus.data_ack !== 1'b0 || bus.bus_err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: dack %b bus_err %b sticky %b expected 0 / 0 / 1",
                     bus.data_ack, bus.bus_err, bus.err_sticky);
        end
    endtask

    task automatic test_spurious_ack();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hDEAD_0001;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if ({bus.inst_ack, bus.data_ack, bus.ram_req} !== 3'b000 || bus.data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL spurious_ack: iack/dack/req %b drdata %h expected 000 / 00000000",
                     {bus.inst_ack, bus.data_ack, bus.ram_req}, bus.data_rdata);
        end
        tick();
        checks++;
        if ({bus.inst_ack, bus.data_ack, bus.ram_req} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_after: iack/dack/req %b expected 000", {bus.inst_ack, bus.data_ack, bus.ram_req});
        end
    endtask

    task automatic test_reset_mid();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h300;
        tick();
        tick();
        checks++;
        if (bus.ram_req !== 1'b1 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: ram_req %b sticky %b expected 1 / 1", bus.ram_req, bus.err_sticky);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ram_req !== 1'b0 || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: ram_req %b sticky %b expected 0 / 0", bus.ram_req, bus.err_sticky);
        end
        bus.ram_ack = 1'b1;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== 1'b0 || bus.ram_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_noack: iack %b ram_req %b expected 0 / 0", bus.inst_ack, bus.ram_req);
        end
        bus.inst_addr = 32'h304;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h304 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_regrant: req %b addr %h we %b expected 1 / 00000304 / 0",
                     bus.ram_req, bus.ram_addr, bus.ram_we);
        end
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'hABCD_0123;
        tick();
        bus.ram_ack = 1'b0;
        checks++;
        if (bus.inst_ack !== 1'b1 || bus.inst_rdata !== 32'hABCD_0123 || bus.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_fetch: iack %b irdata %h bus_err %b expected 1 / abcd0123 / 0",
                     bus.inst_ack, bus.inst_rdata, bus.bus_err);
        end
        bus.inst_req = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_inst_fetch();
        test_priority();
        test_round_robin();
        test_timeout();
        test_spurious_ack();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
